elm_addr_sweep_gen: RTL and testbench
=====================================

// Module: elm_addr_sweep_gen
// PURPOSE
//  Parametrised 2-D address sequencer for ELM weight/input memories.
//  Sweeps COLS x ROWS elements: base + row*stride + col, modulo 2^AW.
//  Has a programmable extent, a start/busy/done handshake, a per-row
//  done flag and a stall enable.
//  Sits between the layer-control FSM and BRAM address ports.
//  Supersedes fixed 256-deep counters.
// PARAMETERS
//  AW  8  address width (addr, base_addr, stride)
//  CW  8  index width (col/row counters and limits)
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   synchronous, active-high reset
//  clr        in   1   synchronous abort; returns to IDLE
//  start      in   1   launch sweep; sampled only in IDLE
//  en         in   1   advance one element when valid
//  base_addr  in   AW  first address; latched at start
//  stride     in   AW  address step between rows; latched at start
//  col_max    in   CW  last column index (COLS-1); latched at start
//  row_max    in   CW  last row index (ROWS-1); latched at start
//  addr       out  AW  current element address
//  col_idx    out  CW  current column index
//  row_idx    out  CW  current row index
//  valid      out  1   addr/idx are meaningful (RUN state)
//  last_col   out  1   valid & col_idx==col_max (combinational)
//  last       out  1   last_col & row_idx==row_max (combinational)
//  busy       out  1   high in RUN
//  done       out  1   1-cycle registered pulse after final element taken
// BEHAVIOUR
//  - Priority: rst > clr > start/en.
//  - rst or clr: state=IDLE.
//    All outputs 0: addr, col_idx, row_idx, valid, busy, done.
//  - IDLE: start=1 latches base/stride/col_max/row_max.
//    Next cycle: state=RUN, valid=1, addr=base_addr, col=row=0.
//    Latched limits are held; input changes during RUN are ignored.
//  - RUN, en=0: every output holds (stall); done stays 0.
//  - RUN, en=1, col<col_max: col+1, addr+1.
//  - RUN, en=1, col==col_max, row<row_max: col=0, row+1,
//    row_base+=stride, addr=new row_base.
//  - RUN, en=1, last=1: state=IDLE, valid=0, busy=0, idx/addr->0.
//    done=1 for exactly that next cycle.
//  - start in RUN is ignored.
//  - start in the cycle done is high (IDLE) is accepted.
//    Gives back-to-back sweeps with one idle cycle.
//  - Address arithmetic: AW-bit unsigned; silent wrap modulo 2^AW.
//    No overflow flag. row_base is an internal AW-bit register.
//  - col_max=row_max=0: single element; last=1 on the first valid cycle.
//  - Max sweep 2^CW x 2^CW. Index counters never exceed the latched
//    limits, so no index wrap.
//  - clr in the same cycle as the final en: clr wins; done stays 0.
//  - Latency: start->first valid 1 cycle.
//    Final en->done 1 cycle. Throughput: 1 element/cycle.
// TESTING
//  1. base=0x10, stride=0x20, col_max=2, row_max=1, en=1:
//     addr 10,11,12,30,31,32; last_col on 12 and 32; last on 32;
//     done 1 cycle later.
//  2. Same sweep, en toggled 1010...: each addr held 2 cycles.
//     Sequence unchanged; done only after the 6th accepted element.
//  3. col_max=row_max=0, base=0x55: one valid cycle with addr=55 and
//     last=1, then done; busy high 1 cycle.
//  4. base=0xFE, stride=0x04, col_max=3, row_max=1:
//     addr FE,FF,00,01,02,03,04,05 (mod-256 wrap).
//  5. clr on the 3rd element of test 1: next cycle valid=0, busy=0,
//     addr=0; no done pulse.
//  6. start pulsed mid-sweep with new base: ignored.
//     start in the done cycle: new sweep begins the following cycle.

Source files
------------

// File: rtl/elm_addr_sweep_gen_if.sv
// Bus bundle for the 2-D address sweep generator: launch controls, latched
// sweep extent, and the per-element address/index stream.
interface elm_addr_sweep_gen_if #(
    parameter int AW = 8,
    parameter int CW = 8
);
    // Handshake: start is taken only while the generator is idle (busy=0).
    // While valid=1 the element on addr/col_idx/row_idx is consumed on every
    // rising edge where en=1; with en=0 the element and all flags hold.
    // done pulses for one cycle after the final element has been consumed.
    logic          clr;
    logic          start;
    logic          en;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] stride;
    logic [CW-1:0] col_max;
    logic [CW-1:0] row_max;

    logic [AW-1:0] addr;
    logic [CW-1:0] col_idx;
    logic [CW-1:0] row_idx;
    logic          valid;
    logic          last_col;
    logic          last;
    logic          busy;
    logic          done;
    logic          fsm_state;

    modport master (
        output clr, start, en, base_addr, stride, col_max, row_max,
        input  addr, col_idx, row_idx, valid, last_col, last, busy, done,
        input  fsm_state
    );

    modport slave (
        input  clr, start, en, base_addr, stride, col_max, row_max,
        output addr, col_idx, row_idx, valid, last_col, last, busy, done,
        output fsm_state
    );
endinterface

// File: rtl/elm_addr_sweep_gen.sv
// 2-D address sequencer: emits base + row*stride + col over a latched
// COLS x ROWS extent, one element per accepted cycle, with AW-bit wrap.
module elm_addr_sweep_gen #(
    parameter int AW = 8,
    parameter int CW = 8
) (
    input logic                clk,
    input logic                rst,
    elm_addr_sweep_gen_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q, state_n;
    logic [AW-1:0] addr_q, addr_n;
    logic [AW-1:0] row_base_q, row_base_n;
    logic [AW-1:0] stride_q, stride_n;
    logic [CW-1:0] col_q, col_n;
    logic [CW-1:0] row_q, row_n;
    logic [CW-1:0] col_max_q, col_max_n;
    logic [CW-1:0] row_max_q, row_max_n;
    logic          done_q, done_n;

    logic          running;
    logic          at_last_col;
    logic          at_last;
    logic [AW-1:0] next_row_base;

    assign running       = (state_q == RUN);
    assign at_last_col   = running && (col_q == col_max_q);
    assign at_last       = at_last_col && (row_q == row_max_q);
    assign next_row_base = row_base_q + stride_q;

    always_comb begin
        state_n    = state_q;
        addr_n     = addr_q;
        row_base_n = row_base_q;
        stride_n   = stride_q;
        col_n      = col_q;
        row_n      = row_q;
        col_max_n  = col_max_q;
        row_max_n  = row_max_q;
        done_n     = 1'b0;

        if (bus.clr) begin
            // Abort wins over a simultaneous final en, so no done pulse here.
            state_n    = IDLE;
            addr_n     = '0;
            row_base_n = '0;
            col_n      = '0;
            row_n      = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_n    = RUN;
                        stride_n   = bus.stride;
                        col_max_n  = bus.col_max;
                        row_max_n  = bus.row_max;
                        addr_n     = bus.base_addr;
                        row_base_n = bus.base_addr;
                        col_n      = '0;
                        row_n      = '0;
                    end
                end
                RUN: begin
                    if (bus.en) begin
                        if (at_last) begin
                            state_n    = IDLE;
                            addr_n     = '0;
                            row_base_n = '0;
                            col_n      = '0;
                            row_n      = '0;
                            done_n     = 1'b1;
                        end else if (!at_last_col) begin
                            col_n  = col_q + 1'b1;
                            addr_n = addr_q + 1'b1;
                        end else begin
                            // Row wrap: restart at the next row origin, not addr+1.
                            col_n      = '0;
                            row_n      = row_q + 1'b1;
                            row_base_n = next_row_base;
                            addr_n     = next_row_base;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            row_base_q <= '0;
            stride_q   <= '0;
            col_q      <= '0;
            row_q      <= '0;
            col_max_q  <= '0;
            row_max_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_n;
            addr_q     <= addr_n;
            row_base_q <= row_base_n;
            stride_q   <= stride_n;
            col_q      <= col_n;
            row_q      <= row_n;
            col_max_q  <= col_max_n;
            row_max_q  <= row_max_n;
            done_q     <= done_n;
        end
    end

    assign bus.addr      = addr_q;
    assign bus.col_idx   = col_q;
    assign bus.row_idx   = row_q;
    assign bus.valid     = running;
    assign bus.busy      = running;
    assign bus.last_col  = at_last_col;
    assign bus.last      = at_last;
    assign bus.done      = done_q;
    assign bus.fsm_state = state_q;

endmodule

// File: tb/tb_elm_addr_sweep_gen.sv
// Bench for elm_addr_sweep_gen: directed sweeps plus randomized sweeps scored
// against an element list computed as (base + row*stride + col) mod 2^AW.
module tb_elm_addr_sweep_gen;
    localparam int AW = 8;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    elm_addr_sweep_gen_if #(.AW(AW), .CW(CW)) bus();

    elm_addr_sweep_gen #(.AW(AW), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Each entry is {row, col, addr}.
    logic [CW+CW+AW-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        bus.clr       = 1'b0;
        bus.start     = 1'b0;
        bus.en        = 1'b0;
        bus.base_addr = '0;
        bus.stride    = '0;
        bus.col_max   = '0;
        bus.row_max   = '0;
    endtask

    task automatic check_quiet(input string tag, input logic exp_done);
        chk({tag, "_valid"},    32'(bus.valid),    32'd0);
        chk({tag, "_busy"},     32'(bus.busy),     32'd0);
        chk({tag, "_addr"},     32'(bus.addr),     32'd0);
        chk({tag, "_col"},      32'(bus.col_idx),  32'd0);
        chk({tag, "_row"},      32'(bus.row_idx),  32'd0);
        chk({tag, "_last_col"}, 32'(bus.last_col), 32'd0);
        chk({tag, "_last"},     32'(bus.last),     32'd0);
        chk({tag, "_done"},     32'(bus.done),     32'(exp_done));
    endtask

    task automatic build_model(input int b, input int s, input int cm, input int rm);
        exp_q.delete();
        for (int r = 0; r <= rm; r++)
            for (int c = 0; c <= cm; c++)
                exp_q.push_back({CW'(r), CW'(c), AW'((b + r * s + c) % (1 << AW))});
    endtask

    // Entered at a negedge; leaves at the negedge of the first valid cycle.
    task automatic launch(input int b, input int s, input int cm, input int rm);
        bus.start     = 1'b1;
        bus.base_addr = AW'(b);
        bus.stride    = AW'(s);
        bus.col_max   = CW'(cm);
        bus.row_max   = CW'(rm);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // mode 0: en always 1; mode 1: en toggles 0,1,0,1...; mode 2: random en.
    // noise scrambles start and the sweep inputs while running.
    task automatic run_body(input int b, input int s, input int cm, input int rm,
                            input int mode, input bit noise, input string tag);
        int cyc;
        int budget;
        logic [CW+CW+AW-1:0] e;
        logic en_v;
        build_model(b, s, cm, rm);
        budget = 4 * exp_q.size() + 16;
        cyc = 0;
        while (exp_q.size() > 0) begin
            if (cyc > budget) begin
                vectors++;
                miscompares++;
                $error("FAIL %s_timeout: got %0d cycles required at most %0d", tag, cyc, budget);
                bus.en = 1'b0;
                return;
            end
            e = exp_q[0];
            chk({tag, "_valid"},    32'(bus.valid),   32'd1);
            chk({tag, "_busy"},     32'(bus.busy),    32'd1);
            chk({tag, "_addr"},     32'(bus.addr),    32'(e[AW-1:0]));
            chk({tag, "_col"},      32'(bus.col_idx), 32'(e[AW +: CW]));
            chk({tag, "_row"},      32'(bus.row_idx), 32'(e[AW+CW +: CW]));
            chk({tag, "_last_col"}, 32'(bus.last_col), 32'(int'(e[AW +: CW]) == cm));
            chk({tag, "_last"},     32'(bus.last),
                32'(int'(e[AW +: CW]) == cm && int'(e[AW+CW +: CW]) == rm));
            chk({tag, "_done"},     32'(bus.done),    32'd0);
            case (mode)
                0:       en_v = 1'b1;
                1:       en_v = cyc[0];
                default: en_v = 1'($urandom_range(0, 1));
            endcase
            bus.en = en_v;
            if (noise) begin
                bus.start     = ($urandom_range(0, 3) == 0);
                bus.base_addr = AW'($urandom);
                bus.stride    = AW'($urandom);
                bus.col_max   = CW'($urandom);
                bus.row_max   = CW'($urandom);
            end
            @(posedge clk);
            if (en_v) void'(exp_q.pop_front());
            @(negedge clk);
            cyc++;
        end
        bus.en    = 1'b0;
        bus.start = 1'b0;
        check_quiet({tag, "_donecyc"}, 1'b1);
    endtask

    initial begin
        int b, s, cm, rm;
        drive_idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset", 1'b0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_quiet("idle", 1'b0);

        // Basic 3x2 sweep at full rate.
        launch(8'h10, 8'h20, 2, 1);
        run_body(8'h10, 8'h20, 2, 1, 0, 1'b0, "t1");
        @(posedge clk);
        @(negedge clk);
        check_quiet("t1_after", 1'b0);

        // Same sweep with alternating stalls.
        launch(8'h10, 8'h20, 2, 1);
        run_body(8'h10, 8'h20, 2, 1, 1, 1'b0, "t2");
        @(posedge clk);
        @(negedge clk);
        check_quiet("t2_after", 1'b0);

        // Single-element sweep.
        launch(8'h55, 8'h00, 0, 0);
        run_body(8'h55, 8'h00, 0, 0, 0, 1'b0, "t3");
        @(posedge clk);
        @(negedge clk);
        check_quiet("t3_after", 1'b0);

        // Address wrap modulo 256.
        launch(8'hFE, 8'h04, 3, 1);
        run_body(8'hFE, 8'h04, 3, 1, 0, 1'b0, "t4");
        @(posedge clk);
        @(negedge clk);

        // Abort on the third element.
        launch(8'h10, 8'h20, 2, 1);
        bus.en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("t5_addr3", 32'(bus.addr), 32'h12);
        bus.clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.clr = 1'b0;
        bus.en  = 1'b0;
        check_quiet("t5_clr", 1'b0);
        @(posedge clk);
        @(negedge clk);
        check_quiet("t5_clr_after", 1'b0);

        // Abort coinciding with the final en: no done pulse.
        launch(8'h33, 8'h01, 0, 0);
        chk("t5b_last", 32'(bus.last), 32'd1);
        bus.en  = 1'b1;
        bus.clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.en  = 1'b0;
        bus.clr = 1'b0;
        check_quiet("t5b_clr_final", 1'b0);

        // Mid-sweep start ignored; start in the done cycle chains a new sweep.
        launch(8'h10, 8'h20, 2, 1);
        run_body(8'h10, 8'h20, 2, 1, 0, 1'b1, "t6a");
        launch(8'hA0, 8'h08, 1, 2);
        run_body(8'hA0, 8'h08, 1, 2, 2, 1'b1, "t6b");
        @(posedge clk);
        @(negedge clk);
        check_quiet("t6_after", 1'b0);

        // Reset in the middle of a sweep.
        launch(8'h40, 8'h10, 3, 3);
        bus.en = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        bus.en = 1'b0;
        check_quiet("rst_mid", 1'b0);

        // Randomized sweeps, some chained back-to-back.
        for (int i = 0; i < 30; i++) begin
            b  = int'($urandom_range(0, 255));
            s  = int'($urandom_range(0, 255));
            cm = int'($urandom_range(0, 4));
            rm = int'($urandom_range(0, 4));
            launch(b, s, cm, rm);
            run_body(b, s, cm, rm, int'($urandom_range(0, 2)), 1'b1, "rnd");
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk);
                @(negedge clk);
                check_quiet("rnd_gap", 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
